// File: rtl/row_codec_pkg.sv
// Shared definitions for the 5-pixel row codec: packet format, decoder
// state encoding and the event record layout.
package row_codec_pkg;

    localparam logic [15:0] PKT_WRAP     = 16'h8000;
    localparam int          PKT_TYPE_BIT = 15;
    localparam int          PIX_W        = 3;
    localparam int          PIX_PER_PKT  = 5;
    localparam int          PIX_BITS     = PIX_W * PIX_PER_PKT;

    localparam int          TS_LO_W_DFLT = 15;
    localparam int          TS_W_DFLT    = 45;

    localparam logic [1:0]  ST_IDLE       = 2'd0;
    localparam logic [1:0]  ST_RUN        = 2'd1;
    localparam logic [1:0]  ST_EXPECT_RAW = 2'd2;

    // kind 0 = pixel event, kind 1 = resume-timestamp event
    typedef struct packed {
        logic                  kind;
        logic [PIX_BITS-1:0]   pixels;
        logic [TS_W_DFLT-1:0]  ts;
    } row_evt_t;

    localparam int ROW_EVT_W = $bits(row_evt_t);

endpackage

// File: rtl/row_evt_fifo.sv
// First-word-fall-through event FIFO; head entry is always visible on rd_data_o.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module row_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 61
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign pop  = rd_en_i && !empty_o;
    assign push = wr_en_i && (!full_o || pop);

    assign rd_data_o = mem_q[rd_ptr_q];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/row_decoder_5p.sv
// Row packet decoder: classifies RAW/TS/WRAP packets, tracks the wrap epoch,
// rebuilds full-width events and queues them for a valid/ready consumer.
module row_decoder_5p
    import row_codec_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TS_LO_W    = TS_LO_W_DFLT,
    parameter int TS_W       = TS_W_DFLT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             encoded_data,
    input  logic                    data_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_kind,
    output logic [PIX_BITS-1:0]     out_pixels,
    output logic [TS_W-1:0]         out_time,
    output logic [TS_W-TS_LO_W-1:0] epoch,
    output logic                    err_overflow,
    output logic                    err_protocol
);

    localparam int EP_W  = TS_W - TS_LO_W;
    localparam int EVT_W = 1 + PIX_BITS + TS_W;

    logic [1:0]          state_q,     state_d;
    logic [EP_W-1:0]     epoch_q,     epoch_d;
    logic [PIX_BITS-1:0] last_pix_q,  last_pix_d;
    logic                dec_valid_q, dec_valid_d;
    logic [EVT_W-1:0]    dec_evt_q,   dec_evt_d;
    logic                err_ovf_q;
    logic                err_proto_q;
    logic                proto_set;

    logic                is_raw;
    logic                is_wrap;
    logic [PIX_BITS-1:0] pix;

    logic [EVT_W-1:0]    fifo_head;
    logic [EVT_W-1:0]    head_gated;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                unused_fifo_count;

    assign is_raw  = !encoded_data[PKT_TYPE_BIT];
    assign is_wrap = (encoded_data == PKT_WRAP);
    assign pix     = encoded_data[PIX_BITS-1:0];

    always_comb begin
        state_d     = state_q;
        epoch_d     = epoch_q;
        last_pix_d  = last_pix_q;
        dec_valid_d = 1'b0;
        dec_evt_d   = dec_evt_q;
        proto_set   = 1'b0;
        if (data_ready) begin
            if (is_wrap) begin
                epoch_d = epoch_q + EP_W'(1);
            end else if (is_raw) begin
                dec_valid_d = 1'b1;
                dec_evt_d   = {1'b0, pix, epoch_q, {TS_LO_W{1'b0}}};
                last_pix_d  = pix;
                state_d     = ST_RUN;
                // A repeated raw word means the encoder lost its change filter.
                if ((state_q == ST_RUN) && (pix == last_pix_q)) begin
                    proto_set = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        proto_set = 1'b1;
                    end
                    ST_RUN: begin
                        dec_valid_d = 1'b1;
                        dec_evt_d   = {1'b1, {PIX_BITS{1'b0}}, epoch_q,
                                       encoded_data[TS_LO_W-1:0]};
                        state_d     = ST_EXPECT_RAW;
                    end
                    default: begin
                        proto_set   = 1'b1;
                        dec_valid_d = 1'b1;
                        dec_evt_d   = {1'b1, {PIX_BITS{1'b0}}, epoch_q,
                                       encoded_data[TS_LO_W-1:0]};
                        state_d     = ST_EXPECT_RAW;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            epoch_q     <= '0;
            last_pix_q  <= '0;
            dec_valid_q <= 1'b0;
            dec_evt_q   <= '0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            epoch_q     <= epoch_d;
            last_pix_q  <= last_pix_d;
            dec_valid_q <= dec_valid_d;
            dec_evt_q   <= dec_evt_d;
            if (proto_set) begin
                err_proto_q <= 1'b1;
            end
            // A full FIFO still takes the event if the head leaves this cycle.
            if (dec_valid_q && fifo_full && !fifo_pop) begin
                err_ovf_q <= 1'b1;
            end
        end
    end

    row_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (dec_valid_q),
        .wr_data_i (dec_evt_q),
        .rd_en_i   (out_ready),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign unused_fifo_count = ^fifo_count;

    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign head_gated = out_valid ? fifo_head : '0;
    assign out_kind   = head_gated[EVT_W-1];
    assign out_pixels = head_gated[EVT_W-2 -: PIX_BITS];
    assign out_time   = head_gated[TS_W-1:0];

    assign epoch        = epoch_q;
    assign err_overflow = err_ovf_q;
    assign err_protocol = err_proto_q;

endmodule

// File: tb/tb_row_decoder_5p.sv
// Directed bench for row_decoder_5p; a second instance with a 3-bit epoch
// exercises the epoch rollover in a handful of cycles.
module tb_row_decoder_5p;
    import row_codec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] encoded_data;
    logic        data_ready;
    logic        out_ready;

    logic        out_valid;
    logic        out_kind;
    logic [14:0] out_pixels;
    logic [44:0] out_time;
    logic [29:0] epoch;
    logic        err_overflow;
    logic        err_protocol;

    logic        s_out_valid;
    logic        s_out_kind;
    logic [14:0] s_out_pixels;
    logic [17:0] s_out_time;
    logic [2:0]  s_epoch;
    logic        s_err_overflow;
    logic        s_err_protocol;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    row_decoder_5p #(.FIFO_DEPTH(4), .TS_LO_W(15), .TS_W(45)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .encoded_data (encoded_data),
        .data_ready   (data_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_pixels   (out_pixels),
        .out_time     (out_time),
        .epoch        (epoch),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    row_decoder_5p #(.FIFO_DEPTH(4), .TS_LO_W(15), .TS_W(18)) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .encoded_data (encoded_data),
        .data_ready   (data_ready),
        .out_valid    (s_out_valid),
        .out_ready    (out_ready),
        .out_kind     (s_out_kind),
        .out_pixels   (s_out_pixels),
        .out_time     (s_out_time),
        .epoch        (s_epoch),
        .err_overflow (s_err_overflow),
        .err_protocol (s_err_protocol)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] pkt);
        encoded_data = pkt;
        data_ready   = 1'b1;
        tick();
        data_ready   = 1'b0;
        encoded_data = 16'h0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        data_ready = 1'b0;
        tick();
        rst_n      = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        encoded_data = 16'h0;
        data_ready   = 1'b0;
        out_ready    = 1'b1;
        tick();
        tick();
        chk("rst_valid",    out_valid,    1'b0);
        chk("rst_epoch",    epoch,        30'd0);
        chk("rst_err_ovf",  err_overflow, 1'b0);
        chk("rst_err_prot", err_protocol, 1'b0);
        chk("rst_pixels",   out_pixels,   15'h0);
        chk("rst_time",     out_time,     45'h0);
        chk("rst_state",    dut.state_q,  ST_IDLE);
        rst_n = 1'b1;
        tick();

        // First raw packet: visible exactly two edges after sampling.
        send(16'h1234);
        chk("lat_not_early", out_valid,   1'b0);
        tick();
        chk("lat_valid",     out_valid,   1'b1);
        chk("lat_kind",      out_kind,    1'b0);
        chk("lat_pixels",    out_pixels,  15'h1234);
        chk("lat_time",      out_time,    45'h0);
        chk("lat_state",     dut.state_q, ST_RUN);

        // RAW, TS, RAW back to back with the consumer always ready.
        send(16'h0001);
        send(16'h8005);
        chk("seq_ev1_kind",  out_kind,   1'b0);
        chk("seq_ev1_pix",   out_pixels, 15'h0001);
        send(16'h0002);
        chk("seq_ev2_kind",  out_kind,   1'b1);
        chk("seq_ev2_time",  out_time,   45'h5);
        chk("seq_ev2_pix",   out_pixels, 15'h0);
        tick();
        chk("seq_ev3_kind",  out_kind,   1'b0);
        chk("seq_ev3_pix",   out_pixels, 15'h0002);
        chk("seq_err_prot",  err_protocol, 1'b0);
        tick();
        chk("seq_drained",   out_valid,  1'b0);

        // Three wraps, then a timestamp carries epoch 3.
        send(16'h8000);
        send(16'h8000);
        send(16'h8000);
        chk("wrap_epoch3",   epoch,      30'd3);
        chk("wrap_no_event", out_valid,  1'b0);
        send(16'h80FF);
        send(16'h0003);
        chk("wrap_ts_kind",  out_kind,   1'b1);
        chk("wrap_ts_time",  out_time,   45'h180FF);
        tick();
        chk("wrap_raw_pix",  out_pixels, 15'h0003);
        chk("wrap_raw_time", out_time,   45'h18000);
        chk("wrap_err_prot", err_protocol, 1'b0);
        tick();

        // Timestamp while idle is dropped and flagged.
        do_reset();
        send(16'h8010);
        tick();
        chk("idle_ts_novalid", out_valid,    1'b0);
        chk("idle_ts_err",     err_protocol, 1'b1);
        chk("idle_ts_state",   dut.state_q,  ST_IDLE);

        // Second timestamp in EXPECT_RAW is flagged but still emitted.
        do_reset();
        send(16'h0004);
        send(16'h8020);
        chk("exp_first_ts_ok", err_protocol, 1'b0);
        send(16'h8030);
        chk("exp_second_err",  err_protocol, 1'b1);
        tick();
        chk("exp_second_kind", out_kind,     1'b1);
        chk("exp_second_time", out_time,     45'h30);
        chk("exp_state",       dut.state_q,  ST_EXPECT_RAW);
        tick();

        // Repeated raw pixels in RUN are flagged and both emitted.
        do_reset();
        send(16'h0005);
        send(16'h0005);
        chk("rep_ev1_pix",  out_pixels,   15'h0005);
        chk("rep_err_prot", err_protocol, 1'b1);
        tick();
        chk("rep_ev2_valid", out_valid,   1'b1);
        tick();

        // Six packets into a stalled 4-deep FIFO.
        do_reset();
        out_ready = 1'b0;
        send(16'h0011);
        send(16'h0012);
        send(16'h0013);
        send(16'h0014);
        send(16'h0015);
        chk("ovf_before",   err_overflow, 1'b0);
        send(16'h0016);
        chk("ovf_set",      err_overflow, 1'b1);
        tick();
        out_ready = 1'b1;
        chk("ovf_head0",    out_pixels, 15'h0011);
        tick();
        chk("ovf_head1",    out_pixels, 15'h0012);
        tick();
        chk("ovf_head2",    out_pixels, 15'h0013);
        tick();
        chk("ovf_head3",    out_pixels, 15'h0014);
        tick();
        chk("ovf_empty",    out_valid,  1'b0);

        // Push and pop in the same cycle while full: no overflow.
        do_reset();
        out_ready = 1'b0;
        send(16'h0021);
        send(16'h0022);
        send(16'h0023);
        send(16'h0024);
        send(16'h0025);
        out_ready = 1'b1;
        tick();
        chk("pp_no_ovf",   err_overflow, 1'b0);
        chk("pp_head0",    out_pixels,   15'h0022);
        tick();
        chk("pp_head1",    out_pixels,   15'h0023);
        tick();
        chk("pp_head2",    out_pixels,   15'h0024);
        tick();
        chk("pp_head3",    out_pixels,   15'h0025);
        tick();
        chk("pp_empty",    out_valid,    1'b0);

        // Epoch rollover on the 3-bit-epoch instance.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(16'h8000);
        end
        chk("ep_small_max", s_epoch, 3'd7);
        chk("ep_big_7",     epoch,   30'd7);
        send(16'h8000);
        chk("ep_small_wrap", s_epoch, 3'd0);
        chk("ep_big_8",      epoch,   30'd8);

        // Reset with a non-empty FIFO and a sticky error set.
        out_ready = 1'b0;
        send(16'h0031);
        send(16'h8040);
        send(16'h8041);
        tick();
        chk("pre_rst_valid", out_valid,    1'b1);
        chk("pre_rst_pix",   out_pixels,   15'h0031);
        chk("pre_rst_err",   err_protocol, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid,    1'b0);
        chk("mid_rst_epoch", epoch,        30'd0);
        chk("mid_rst_eprot", err_protocol, 1'b0);
        chk("mid_rst_eovf",  err_overflow, 1'b0);
        chk("mid_rst_time",  out_time,     45'h0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
